// File: rtl/uart_pkg.sv
// Shared UART/TAP constants: instruction-register width and reserved addresses.
package uart_pkg;

  localparam int IRLENGTH = 5;

  // Reported by the interconnect when no peripheral holds valid data.
  localparam logic [IRLENGTH-1:0] ADDR_NOP     = 5'h1F;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h02;

endpackage

// File: rtl/tap_read_arbiter.sv
// Read side of the TAP read interconnect.
// Takes host read requests (or self-initiates reads of peripherals flagged
// valid), retries the read-ready pulse until data arrives, then streams the
// captured word LSB-first as bytes to the UART transmitter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | ready for a host request or an auto read
//   ISSUE    | one-cycle read-ready pulse to the interconnect
//   WAIT     | sample read valid; retry, give up, or capture the data
//   SEND_HDR | auto reads only: header byte 8'h80 | address
//   SEND     | data bytes, LSB first
module tap_read_arbiter
  import uart_pkg::*;
#(
  parameter int READ_WIDTH = 32,
  parameter int MAX_RETRY  = 16
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic [IRLENGTH-1:0]   REQ_ADDRESS_I,
  input  logic                  REQ_VALID_I,
  output logic                  REQ_READY_O,
  input  logic                  AUTO_EN_I,
  output logic [IRLENGTH-1:0]   READ_ADDRESS_O,
  output logic                  READ_READY_O,
  input  logic [READ_WIDTH-1:0] READ_DATA_I,
  input  logic                  READ_VALID_I,
  input  logic [IRLENGTH-1:0]   VALID_ADDRESS_I,
  output logic [7:0]            TX_DATA_O,
  output logic                  TX_VALID_O,
  input  logic                  TX_READY_I,
  output logic                  ERR_O,
  output logic                  BUSY_O
);

  localparam int NBYTES  = (READ_WIDTH + 7) / 8;
  localparam int SHIFT_W = NBYTES * 8;
  localparam int BCNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [BCNT_W-1:0]  LAST_BYTE  = BCNT_W'(NBYTES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SEND_HDR,
    S_SEND
  } state_t;

  state_t               state_q;
  state_t               state_next;
  logic [IRLENGTH-1:0]  addr_q;
  logic                 auto_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [RETRY_W-1:0]   retry_q;
  logic [BCNT_W-1:0]    byte_q;
  logic                 err_q;
  logic                 req_ready_q;

  logic auto_hit;
  logic start;
  logic retry_done;
  logic last_byte;

  // req_ready_q is low through reset and the first cycle after it, so an
  // acceptance is only ever seen by the host while REQ_READY_O is high.
  assign auto_hit   = AUTO_EN_I && (VALID_ADDRESS_I != ADDR_NOP);
  assign start      = req_ready_q && (REQ_VALID_I || auto_hit);
  assign retry_done = (retry_q >= RETRY_LAST);
  assign last_byte  = (byte_q == LAST_BYTE);

  // State register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= S_IDLE;
    else       state_q <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:     if (start) state_next = S_ISSUE;
      S_ISSUE:    state_next = S_WAIT;
      S_WAIT: begin
        if (READ_VALID_I || retry_done) state_next = auto_q ? S_SEND_HDR : S_SEND;
        else                            state_next = S_ISSUE;
      end
      S_SEND_HDR: if (TX_READY_I) state_next = S_SEND;
      S_SEND:     if (TX_READY_I && last_byte) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Address latch, data capture/shift, retry and byte counters, error pulse.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      addr_q      <= ADDR_NOP;
      auto_q      <= 1'b0;
      shift_q     <= '0;
      retry_q     <= '0;
      byte_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      err_q       <= 1'b0;
      req_ready_q <= (state_next == S_IDLE);
      case (state_q)
        S_IDLE: begin
          byte_q <= '0;
          if (req_ready_q) begin
            if (REQ_VALID_I) begin
              addr_q <= REQ_ADDRESS_I;
              auto_q <= 1'b0;
            end else if (auto_hit) begin
              addr_q <= VALID_ADDRESS_I;
              auto_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (READ_VALID_I) begin
            shift_q <= SHIFT_W'(READ_DATA_I);
            retry_q <= '0;
          end else if (!retry_done) begin
            retry_q <= retry_q + 1'b1;
          end else begin
            shift_q <= '0;
            err_q   <= 1'b1;
            retry_q <= '0;
          end
        end
        S_SEND: begin
          if (TX_READY_I) begin
            shift_q <= shift_q >> 8;
            byte_q  <= last_byte ? '0 : byte_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign REQ_READY_O    = req_ready_q;
  assign BUSY_O         = (state_q != S_IDLE);
  assign READ_READY_O   = (state_q == S_ISSUE);
  assign READ_ADDRESS_O = (state_q == S_IDLE) ? ADDR_NOP : addr_q;
  assign TX_VALID_O     = (state_q == S_SEND_HDR) || (state_q == S_SEND);
  assign TX_DATA_O      = (state_q == S_SEND_HDR) ? (8'h80 | {{(8-IRLENGTH){1'b0}}, addr_q}) :
                          (state_q == S_SEND)     ? shift_q[7:0] : 8'h00;
  assign ERR_O          = err_q;

endmodule

// File: tb/tb_tap_read_arbiter.sv
// Bench for tap_read_arbiter: transaction-level reference model (pulse count,
// error flag, byte list, latency) against randomized peripheral/TX behaviour.
module tb_tap_read_arbiter;
  import uart_pkg::*;

  localparam int RW = 32;
  localparam int MR = 16;
  localparam int NB = 4;

  logic                CLK_I = 1'b0;
  logic                RST_I = 1'b0;
  logic [IRLENGTH-1:0] REQ_ADDRESS_I = '0;
  logic                REQ_VALID_I = 1'b0;
  logic                REQ_READY_O;
  logic                AUTO_EN_I = 1'b0;
  logic [IRLENGTH-1:0] READ_ADDRESS_O;
  logic                READ_READY_O;
  logic [RW-1:0]       READ_DATA_I = '0;
  logic                READ_VALID_I = 1'b0;
  logic [IRLENGTH-1:0] VALID_ADDRESS_I = ADDR_NOP;
  logic [7:0]          TX_DATA_O;
  logic                TX_VALID_O;
  logic                TX_READY_I = 1'b0;
  logic                ERR_O;
  logic                BUSY_O;

  int checks = 0;
  int errors = 0;

  tap_read_arbiter #(.READ_WIDTH(RW), .MAX_RETRY(MR)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .REQ_ADDRESS_I(REQ_ADDRESS_I), .REQ_VALID_I(REQ_VALID_I), .REQ_READY_O(REQ_READY_O),
    .AUTO_EN_I(AUTO_EN_I), .READ_ADDRESS_O(READ_ADDRESS_O), .READ_READY_O(READ_READY_O),
    .READ_DATA_I(READ_DATA_I), .READ_VALID_I(READ_VALID_I), .VALID_ADDRESS_I(VALID_ADDRESS_I),
    .TX_DATA_O(TX_DATA_O), .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I),
    .ERR_O(ERR_O), .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  // One complete read. mode: 0 = TX always ready, 1 = random stalls, 2 = toggle.
  // abort_after >= 0 returns right after that many bytes have been handed over.
  task automatic run_txn(input bit use_host, input bit use_auto,
                         input logic [IRLENGTH-1:0] haddr, input logic [IRLENGTH-1:0] vaddr,
                         input int fails, input logic [31:0] data,
                         input int mode, input int abort_after);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [IRLENGTH-1:0] exp_addr;
    logic [31:0] word;
    int exp_pulses, exp_err, npulse, nerr, cyc, first_tx, last_acc;
    bit accepted, hold, done, prev_valid, prev_ready, tog, r;
    logic [7:0] prev_data;

    exp_addr   = use_host ? haddr : vaddr;
    exp_pulses = (fails >= MR) ? MR : fails + 1;
    exp_err    = (fails >= MR) ? 1 : 0;
    word       = exp_err ? 32'h0 : data;
    if (!use_host) exp_q.push_back(8'h80 | 8'(vaddr));
    for (int i = 0; i < NB; i++) exp_q.push_back(word[8*i +: 8]);

    accepted = 0;
    for (int w = 0; w < 10 && !accepted; w++) begin
      @(negedge CLK_I);
      REQ_VALID_I = use_host; REQ_ADDRESS_I = haddr;
      AUTO_EN_I = use_auto;   VALID_ADDRESS_I = vaddr;
      TX_READY_I = 1'b0;
      READ_VALID_I = 1'($urandom_range(1)); READ_DATA_I = $urandom;
      if (REQ_READY_O === 1'b1) accepted = 1;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL accept: REQ_READY_O=%b, want 1 within 10 cycles", REQ_READY_O);
      return;
    end

    cyc = 0; npulse = 0; nerr = 0; first_tx = -1; last_acc = -1;
    hold = 0; done = 0; prev_valid = 0; prev_ready = 0; prev_data = 8'h00; tog = 0;
    while (!done && cyc < 200) begin
      @(negedge CLK_I);
      cyc++;
      REQ_VALID_I = 1'b0; AUTO_EN_I = 1'b0; VALID_ADDRESS_I = ADDR_NOP;
      REQ_ADDRESS_I = IRLENGTH'($urandom);
      if (BUSY_O !== 1'b1) begin
        checks++;
        if (REQ_READY_O !== 1'b1 || last_acc != cyc - 1) begin
          errors++;
          $display("FAIL idle_return: REQ_READY_O=%b last_byte_cycle=%0d now=%0d, want 1 and now-1",
                   REQ_READY_O, last_acc, cyc);
        end
        checks++;
        if (READ_ADDRESS_O !== ADDR_NOP) begin
          errors++;
          $display("FAIL idle_addr: READ_ADDRESS_O=%h, want %h", READ_ADDRESS_O, ADDR_NOP);
        end
        done = 1;
      end else begin
        checks++;
        if (REQ_READY_O !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: REQ_READY_O=%b at cycle %0d, want 0", REQ_READY_O, cyc);
        end
        if (READ_READY_O === 1'b1) begin
          checks++;
          if (cyc != 2*npulse + 1) begin
            errors++;
            $display("FAIL pulse_timing: pulse %0d at cycle %0d, want %0d", npulse, cyc, 2*npulse+1);
          end
          checks++;
          if (READ_ADDRESS_O !== exp_addr) begin
            errors++;
            $display("FAIL read_addr: READ_ADDRESS_O=%h, want %h", READ_ADDRESS_O, exp_addr);
          end
          READ_VALID_I = (npulse >= fails);
          READ_DATA_I  = data;
          hold = 1;
          npulse++;
        end else if (hold) begin
          hold = 0;
        end else begin
          READ_VALID_I = 1'($urandom_range(1));
          READ_DATA_I  = $urandom;
        end
        if (ERR_O === 1'b1) nerr++;
        case (mode)
          0:       r = 1;
          1:       r = ($urandom_range(99) >= 40);
          default: begin tog = !tog; r = tog; end
        endcase
        TX_READY_I = r;
        if (TX_VALID_O === 1'b1) begin
          if (prev_valid && !prev_ready) begin
            checks++;
            if (TX_DATA_O !== prev_data) begin
              errors++;
              $display("FAIL stall_stable: TX_DATA_O=%h, want %h", TX_DATA_O, prev_data);
            end
          end
          if (first_tx < 0) first_tx = cyc;
          if (r) begin got_q.push_back(TX_DATA_O); last_acc = cyc; end
        end
        prev_valid = (TX_VALID_O === 1'b1); prev_ready = r; prev_data = TX_DATA_O;
        if (abort_after >= 0 && got_q.size() == abort_after) return;
      end
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: BUSY_O=%b after %0d cycles, want 0", BUSY_O, cyc);
    end
    checks++;
    if (npulse != exp_pulses) begin
      errors++;
      $display("FAIL pulse_count: got %0d, want %0d", npulse, exp_pulses);
    end
    checks++;
    if (nerr != exp_err) begin
      errors++;
      $display("FAIL err_count: got %0d, want %0d", nerr, exp_err);
    end
    checks++;
    if (first_tx != 2*exp_pulses + 1) begin
      errors++;
      $display("FAIL first_tx_latency: cycle %0d, want %0d", first_tx, 2*exp_pulses+1);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL byte_count: got %0d, want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL byte[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input bit want_ready);
    checks++;
    if (REQ_READY_O !== want_ready || READ_READY_O !== 1'b0 || READ_ADDRESS_O !== ADDR_NOP ||
        TX_VALID_O !== 1'b0 || TX_DATA_O !== 8'h00 || ERR_O !== 1'b0 || BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rr=%b addr=%h txv=%b txd=%h err=%b busy=%b, want %b 0 %h 0 00 0 0",
               REQ_READY_O, READ_READY_O, READ_ADDRESS_O, TX_VALID_O, TX_DATA_O, ERR_O, BUSY_O,
               want_ready, ADDR_NOP);
    end
  endtask

  task automatic test_reset();
    #2 RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    check_reset_outputs(1'b0);
    RST_I = 1'b0;
    @(negedge CLK_I);
    check_reset_outputs(1'b1);
  endtask

  task automatic test_host_immediate();
    run_txn(1, 0, 5'h03, ADDR_NOP, 0, 32'hDEADBEEF, 0, -1);
  endtask

  task automatic test_retry();
    run_txn(1, 0, 5'h07, ADDR_NOP, 3, 32'h12345678, 0, -1);
  endtask

  task automatic test_exhaust();
    run_txn(1, 0, 5'h0A, ADDR_NOP, 1000, 32'hCAFEF00D, 0, -1);
  endtask

  task automatic test_auto();
    run_txn(0, 1, 5'h00, ADDR_STB0_CS, 0, 32'h000000A5, 0, -1);
  endtask

  task automatic test_priority();
    run_txn(1, 1, 5'h11, ADDR_STB0_CS, 1, 32'h0BADF00D, 0, -1);
  endtask

  task automatic test_toggle_reset();
    run_txn(1, 0, 5'h06, ADDR_NOP, 0, 32'h89ABCDEF, 2, 2);
    @(negedge CLK_I);
    checks++;
    if (TX_VALID_O !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame: TX_VALID_O=%b before reset, want 1", TX_VALID_O);
    end
    RST_I = 1'b1;
    #1;
    check_reset_outputs(1'b0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    TX_READY_I = 1'b1;
    @(negedge CLK_I);
    check_reset_outputs(1'b1);
    run_txn(1, 0, 5'h09, ADDR_NOP, 2, 32'h5A5AC3C3, 2, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      bit h, a;
      h = 1'($urandom_range(1));
      a = !h || 1'($urandom_range(1));
      run_txn(h, a, IRLENGTH'($urandom), IRLENGTH'($urandom_range(0, 30)),
              int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 2)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_host_immediate();
    test_retry();
    test_exhaust();
    test_auto();
    test_priority();
    test_toggle_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_read_arbiter.md
# tap_read_arbiter

- Drives the read side of the TAP read interconnect.
- Accepts read requests from the UART command decoder, or self-initiates reads of peripherals the interconnect reports as valid.
- Pulses the interconnect's read-ready, retries until the addressed peripheral returns valid data, then streams the captured word LSB-first as bytes to the UART transmitter.
- Sits between the command decoder / interconnect and the UART TX byte path.

## Interface
- READ_WIDTH, 32: width of interconnect read data; frame carries NBYTES = ceil(READ_WIDTH/8) data bytes.
- MAX_RETRY, 16: read-ready pulses issued per transaction before giving up (≥1).
- IRLENGTH and ADDR_NOP come from uart_pkg; IRLENGTH ≤ 7 is required.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  asynchronous, active-high reset.
- REQ_ADDRESS_I  in  IRLENGTH  host read address.
- REQ_VALID_I  in  1  host request valid.
- REQ_READY_O  out  1  request accepted when high together with REQ_VALID_I.
- AUTO_EN_I  in  1  enables self-initiated reads.
- READ_ADDRESS_O  out  IRLENGTH  address to interconnect.
- READ_READY_O  out  1  read-ready pulse to interconnect.
- READ_DATA_I  in  READ_WIDTH  registered read data from interconnect.
- READ_VALID_I  in  1  registered read valid from interconnect.
- VALID_ADDRESS_I  in  IRLENGTH  address of a peripheral holding valid data; ADDR_NOP when none.
- TX_DATA_O  out  8  byte to UART TX.
- TX_VALID_O  out  1  byte valid.
- TX_READY_I  in  1  UART TX accepts byte.
- ERR_O  out  1  one-cycle pulse when a read exhausts its retries.
- BUSY_O  out  1  high in every state except IDLE.

## Operation

States: IDLE, ISSUE, WAIT, SEND_HDR, SEND.

**IDLE**
- REQ_READY_O=1.
- If REQ_VALID_I=1: latch REQ_ADDRESS_I, clear the auto flag, go to ISSUE.
- Else if AUTO_EN_I=1 and VALID_ADDRESS_I≠ADDR_NOP: latch VALID_ADDRESS_I, set the auto flag, go to ISSUE.
- A host request has priority over an auto read in the same cycle.

**ISSUE**
- READ_READY_O=1 for exactly this one cycle; READ_ADDRESS_O holds the latched address.
- Next state: WAIT.

**WAIT**
- READ_VALID_I is sampled only in this state. Its value outside WAIT is stale and must be ignored.
- Valid=1: capture READ_DATA_I into the shift register, clear the retry count, go to SEND_HDR if auto else SEND.
- Valid=0 and retry count < MAX_RETRY-1: increment the retry count, return to ISSUE.
- Valid=0 and retries exhausted: load all-zero data, pulse ERR_O, clear the retry count, proceed as for valid.

**SEND_HDR**
- TX_VALID_O=1, TX_DATA_O = 8'h80 | zero-extended address.
- On TX_READY_I=1: go to SEND.

**SEND**
- TX_VALID_O=1, TX_DATA_O = shift[7:0].
- On TX_READY_I=1: shift right by 8, increment the byte counter.
- After byte NBYTES-1 is accepted: go to IDLE.
- The top byte is zero-padded when READ_WIDTH is not a multiple of 8.

**General rules**
- READ_ADDRESS_O = ADDR_NOP in IDLE; otherwise the latched address.
- TX_DATA_O stays stable while TX_VALID_O=1 and TX_READY_I=0.
- Inputs are ignored while BUSY_O=1. REQ_VALID_I must be held until accepted.

## Timing
- All outputs are registered or pure state decodes; no input-to-output combinational path.
- Reset values: REQ_READY_O=0 during reset, then 1 in IDLE; READ_READY_O=0, READ_ADDRESS_O=ADDR_NOP, TX_VALID_O=0, TX_DATA_O=0, ERR_O=0, BUSY_O=0; state IDLE; all counters 0.
- Reset asserted mid-transaction aborts the frame immediately: TX_VALID_O falls asynchronously and no partial bytes resume.
- Host latency:
  - acceptance at edge 0;
  - READ_READY_O high in cycle 1;
  - READ_VALID_I sampled in cycle 2;
  - first TX_VALID_O in cycle 3 (cycle 4 for data on auto reads).
- Each failed retry costs 2 cycles (ISSUE+WAIT).
- Worst case before the first byte: 2·MAX_RETRY+1 cycles after acceptance.
- Back-to-back: IDLE lasts at least one cycle between transactions, so REQ_READY_O rises the cycle after the last byte is accepted.
- The byte counter is log2-sized for NBYTES and wraps to 0 on return to IDLE.
- The retry counter is $clog2(MAX_RETRY+1) bits and never overflows.

## Test plan
- Host read, peripheral immediately valid with READ_DATA_I=32'hDEADBEEF, TX_READY_I=1 → READ_READY_O pulsed once; bytes EF, BE, AD, DE on cycles 3–6; no ERR_O.
- Host read, READ_VALID_I=0 for the first 3 pulses then 1 with data 32'h12345678 → exactly 4 READ_READY_O pulses 2 cycles apart; bytes 78, 56, 34, 12.
- Peripheral never valid, MAX_RETRY=16 → 16 pulses, one ERR_O pulse, four 00 bytes, then back to IDLE.
- AUTO_EN_I=1, VALID_ADDRESS_I=ADDR_STB0_CS, data 32'h000000A5 → header byte 8'h80|ADDR_STB0_CS, then A5, 00, 00, 00; REQ_READY_O=0 throughout the frame.
- REQ_VALID_I and an auto-valid address in the same IDLE cycle → the host address is issued and no header byte is sent.
- TX_READY_I toggling 0/1 every cycle, with RST_I asserted after the second byte → TX_DATA_O is stable during stalls; on reset all outputs return to reset values at once and the next request starts a fresh frame.
